// File: rtl/disp_pkg.sv
// disp_pkg: shared definitions for the display capture sequencer.
// Holds the time FSM state encoding and the default depths/mid-scale value.
package disp_pkg;

   typedef enum logic [1:0] {
      TS_IDLE    = 2'd0,
      TS_ARM     = 2'd1,
      TS_CAPTURE = 2'd2,
      TS_DONE    = 2'd3
   } timeState_e;

   localparam int MIDSCALE   = 128;
   localparam int TIME_DEPTH = 640;
   localparam int FREQ_DEPTH = 512;

endpackage

// File: rtl/disp_capture_seq_if.sv
// disp_capture_seq_if: sample/bin inputs and memory write-port outputs of the
// capture sequencer. The datapath side uses 'master', the sequencer 'slave'.
interface disp_capture_seq_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8
);
   logic              frameSync;
   logic              holdDisplay;
   logic [DATA_W-1:0] trigLevel;
   logic              timeValid;
   logic [DATA_W-1:0] timeData;
   logic              freqValid;
   logic [DATA_W-1:0] freqData;
   logic              freqLast;
   logic              enaTime;
   logic              weaTime;
   logic [ADDR_W-1:0] addraTime;
   logic [DATA_W-1:0] dinaTime;
   logic              enaFreq;
   logic              weaFreq;
   logic [ADDR_W-1:0] addraFreq;
   logic [DATA_W-1:0] dinaFreq;
   logic              captureDone;
   logic [1:0]        timeState;

   modport master (
      output frameSync, holdDisplay, trigLevel, timeValid, timeData,
             freqValid, freqData, freqLast,
      input  enaTime, weaTime, addraTime, dinaTime,
             enaFreq, weaFreq, addraFreq, dinaFreq, captureDone, timeState
   );

   modport slave (
      input  frameSync, holdDisplay, trigLevel, timeValid, timeData,
             freqValid, freqData, freqLast,
      output enaTime, weaTime, addraTime, dinaTime,
             enaFreq, weaFreq, addraFreq, dinaFreq, captureDone, timeState
   );
endinterface

// File: rtl/disp_freq_writer.sv
// disp_freq_writer: writes each FFT magnitude frame into the freq memory,
// starting at address 0 every frame. The hold request is sampled once at the
// first bin of a frame so a frame is either stored whole or not at all.
module disp_freq_writer #(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 8,
   parameter int FREQ_DEPTH = 512
)(
   input  logic              ck100MHz,
   input  logic              rst,
   input  logic              holdDisplay,
   input  logic              freqValid,
   input  logic [DATA_W-1:0] freqData,
   input  logic              freqLast,
   output logic              enaFreq,
   output logic              weaFreq,
   output logic [ADDR_W-1:0] addraFreq,
   output logic [DATA_W-1:0] dinaFreq
);
   localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(FREQ_DEPTH);

   logic              frameStart_r;
   logic              freqHold_r;
   logic [ADDR_W-1:0] freqAddr_r;
   logic              holdEff_s;
   logic              wrEn_s;
   logic [ADDR_W-1:0] addrNext_s;

   // Effective hold, write qualification and next bin address
   always_comb begin
      holdEff_s  = freqHold_r;
      wrEn_s     = 1'b0;
      addrNext_s = freqAddr_r;
      if (frameStart_r) begin
         holdEff_s = holdDisplay;
      end else begin
         holdEff_s = freqHold_r;
      end
      if (freqValid && !holdEff_s && (freqAddr_r < DEPTH_A)) begin
         wrEn_s = 1'b1;
      end else begin
         wrEn_s = 1'b0;
      end
      if (freqLast) begin
         addrNext_s = {ADDR_W{1'b0}};
      end else if (freqAddr_r < DEPTH_A) begin
         addrNext_s = freqAddr_r + ADDR_W'(1);
      end else begin
         addrNext_s = freqAddr_r;
      end
   end

   // Frame tracking: hold latch, frame-start flag and saturating bin address
   always_ff @(posedge ck100MHz or posedge rst) begin
      if (rst) begin
         frameStart_r <= 1'b1;
         freqHold_r   <= 1'b0;
         freqAddr_r   <= {ADDR_W{1'b0}};
      end else if (freqValid) begin
         if (frameStart_r) begin
            freqHold_r <= holdDisplay;
         end
         frameStart_r <= freqLast;
         freqAddr_r   <= addrNext_s;
      end
   end

   // Registered write port toward the freq memory
   always_ff @(posedge ck100MHz or posedge rst) begin
      if (rst) begin
         enaFreq   <= 1'b0;
         weaFreq   <= 1'b0;
         addraFreq <= {ADDR_W{1'b0}};
         dinaFreq  <= {DATA_W{1'b0}};
      end else begin
         enaFreq <= wrEn_s;
         weaFreq <= wrEn_s;
         if (wrEn_s) begin
            addraFreq <= freqAddr_r;
            dinaFreq  <= freqData;
         end
      end
   end
endmodule

// File: rtl/disp_capture_seq.sv
// disp_capture_seq: write-side sequencer for the time- and freq-domain display
// memories. Time path: rising-edge level trigger then a single-shot capture,
// re-armed by frameSync. Freq path lives in disp_freq_writer.
// Build macro AUTO_TRIG_EN: ARM forces a capture on the TRIG_TIMEOUT-th strobe.
module disp_capture_seq #(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 8,
   parameter int TIME_DEPTH = disp_pkg::TIME_DEPTH,
   parameter int FREQ_DEPTH = disp_pkg::FREQ_DEPTH
`ifdef AUTO_TRIG_EN
   ,
   parameter int TRIG_TIMEOUT = 4096
`endif
)(
   input logic               ck100MHz,
   input logic               rst,
   disp_capture_seq_if.slave bus
);
   import disp_pkg::*;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TIME_DEPTH - 1);

   timeState_e        state_r;
   timeState_e        nextState_s;
   logic [DATA_W-1:0] prevSample_r;
   logic [ADDR_W-1:0] wrCnt_r;
   logic [ADDR_W-1:0] wrCntNext_s;
   logic              wrEn_s;
   logic [ADDR_W-1:0] wrAddr_s;
   logic              doneNext_s;
   logic              trigHit_s;
   logic              enaTime_r;
   logic [ADDR_W-1:0] addraTime_r;
   logic [DATA_W-1:0] dinaTime_r;
   logic              captureDone_r;

`ifdef AUTO_TRIG_EN
   localparam int TO_W = $clog2(TRIG_TIMEOUT) + 1;
   logic [TO_W-1:0] toCnt_r;

   // Timeout counter of strobes seen in ARM, cleared on entry to ARM
   always_ff @(posedge ck100MHz or posedge rst) begin
      if (rst) begin
         toCnt_r <= {TO_W{1'b0}};
      end else if ((state_r != TS_ARM) && (nextState_s == TS_ARM)) begin
         toCnt_r <= {TO_W{1'b0}};
      end else if ((state_r == TS_ARM) && bus.timeValid) begin
         toCnt_r <= toCnt_r + TO_W'(1);
      end
   end

   // Level crossing or timeout on the current strobe
   always_comb begin
      trigHit_s = 1'b0;
      if (bus.timeValid &&
          (((prevSample_r < bus.trigLevel) && (bus.timeData >= bus.trigLevel)) ||
           (toCnt_r == TO_W'(TRIG_TIMEOUT - 1)))) begin
         trigHit_s = 1'b1;
      end else begin
         trigHit_s = 1'b0;
      end
   end
`else
   // Level crossing on the current strobe (unsigned compare)
   always_comb begin
      trigHit_s = 1'b0;
      if (bus.timeValid && (prevSample_r < bus.trigLevel) &&
          (bus.timeData >= bus.trigLevel)) begin
         trigHit_s = 1'b1;
      end else begin
         trigHit_s = 1'b0;
      end
   end
`endif

   // Time FSM state register
   always_ff @(posedge ck100MHz or posedge rst) begin
      if (rst) begin
         state_r <= TS_IDLE;
      end else begin
         state_r <= nextState_s;
      end
   end

   // Time FSM next-state logic; hold always wins over a trigger or a write
   always_comb begin
      nextState_s = state_r;
      case (state_r)
         TS_IDLE: begin
            if (bus.frameSync && !bus.holdDisplay) nextState_s = TS_ARM;
            else                                   nextState_s = TS_IDLE;
         end
         TS_ARM: begin
            if (bus.holdDisplay)  nextState_s = TS_DONE;
            else if (trigHit_s)   nextState_s = TS_CAPTURE;
            else                  nextState_s = TS_ARM;
         end
         TS_CAPTURE: begin
            if (bus.holdDisplay)                          nextState_s = TS_DONE;
            else if (bus.timeValid && (wrCnt_r == LAST_ADDR)) nextState_s = TS_DONE;
            else                                          nextState_s = TS_CAPTURE;
         end
         TS_DONE: begin
            if (bus.frameSync && !bus.holdDisplay) nextState_s = TS_ARM;
            else                                   nextState_s = TS_DONE;
         end
         default: nextState_s = TS_IDLE;
      endcase
   end

   // Time FSM outputs: write request, address, completion and counter update
   always_comb begin
      wrEn_s      = 1'b0;
      wrAddr_s    = wrCnt_r;
      doneNext_s  = 1'b0;
      wrCntNext_s = wrCnt_r;
      case (state_r)
         TS_ARM: begin
            if (!bus.holdDisplay && trigHit_s) begin
               wrEn_s      = 1'b1;
               wrAddr_s    = {ADDR_W{1'b0}};
               wrCntNext_s = ADDR_W'(1);
            end else begin
               wrCntNext_s = {ADDR_W{1'b0}};
            end
         end
         TS_CAPTURE: begin
            if (!bus.holdDisplay && bus.timeValid) begin
               wrEn_s = 1'b1;
               if (wrCnt_r == LAST_ADDR) begin
                  doneNext_s  = 1'b1;
                  wrCntNext_s = {ADDR_W{1'b0}};
               end else begin
                  wrCntNext_s = wrCnt_r + ADDR_W'(1);
               end
            end else begin
               wrCntNext_s = wrCnt_r;
            end
         end
         default: begin
            wrCntNext_s = {ADDR_W{1'b0}};
         end
      endcase
   end

   // Capture write counter and previous-sample history (updated in every state)
   always_ff @(posedge ck100MHz or posedge rst) begin
      if (rst) begin
         wrCnt_r      <= {ADDR_W{1'b0}};
         prevSample_r <= DATA_W'(MIDSCALE);
      end else begin
         wrCnt_r <= wrCntNext_s;
         if (bus.timeValid) begin
            prevSample_r <= bus.timeData;
         end
      end
   end

   // Registered write port toward the time memory and the done pulse
   always_ff @(posedge ck100MHz or posedge rst) begin
      if (rst) begin
         enaTime_r     <= 1'b0;
         addraTime_r   <= {ADDR_W{1'b0}};
         dinaTime_r    <= {DATA_W{1'b0}};
         captureDone_r <= 1'b0;
      end else begin
         enaTime_r     <= wrEn_s;
         captureDone_r <= doneNext_s;
         if (wrEn_s) begin
            addraTime_r <= wrAddr_s;
            dinaTime_r  <= bus.timeData;
         end
      end
   end

   assign bus.enaTime     = enaTime_r;
   assign bus.weaTime     = enaTime_r;
   assign bus.addraTime   = addraTime_r;
   assign bus.dinaTime    = dinaTime_r;
   assign bus.captureDone = captureDone_r;
   assign bus.timeState   = state_r;

   logic              enaFreq_s;
   logic              weaFreq_s;
   logic [ADDR_W-1:0] addraFreq_s;
   logic [DATA_W-1:0] dinaFreq_s;

   disp_freq_writer #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .FREQ_DEPTH (FREQ_DEPTH)
   ) uFreqWriter (
      .ck100MHz    (ck100MHz),
      .rst         (rst),
      .holdDisplay (bus.holdDisplay),
      .freqValid   (bus.freqValid),
      .freqData    (bus.freqData),
      .freqLast    (bus.freqLast),
      .enaFreq     (enaFreq_s),
      .weaFreq     (weaFreq_s),
      .addraFreq   (addraFreq_s),
      .dinaFreq    (dinaFreq_s)
   );

   assign bus.enaFreq   = enaFreq_s;
   assign bus.weaFreq   = weaFreq_s;
   assign bus.addraFreq = addraFreq_s;
   assign bus.dinaFreq  = dinaFreq_s;
endmodule

// File: tb/tb_disp_capture_seq.sv
// tb_disp_capture_seq: directed scenarios for the display capture sequencer.
module tb_disp_capture_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   disp_capture_seq_if bus();

   disp_capture_seq dut (
      .ck100MHz (clk),
      .rst      (rst),
      .bus      (bus)
   );

   int nCmp = 0;
   int nBad = 0;

   logic [9:0] tAddr [8192];
   logic [7:0] tData [8192];
   int         tN = 0;
   logic [9:0] fAddr [4096];
   logic [7:0] fData [4096];
   int         fN = 0;
   int         cdN = 0;
   int         weBad = 0;

   // Log every memory write seen on the falling edge
   always @(negedge clk) begin
      if (bus.enaTime === 1'b1 && tN < 8192) begin
         tAddr[tN] = bus.addraTime;
         tData[tN] = bus.dinaTime;
         tN++;
      end
      if (bus.enaFreq === 1'b1 && fN < 4096) begin
         fAddr[fN] = bus.addraFreq;
         fData[fN] = bus.dinaFreq;
         fN++;
      end
      if (bus.captureDone === 1'b1) cdN++;
      if (bus.enaTime !== bus.weaTime || bus.enaFreq !== bus.weaFreq) weBad++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic sendT(input logic [7:0] v);
      bus.timeValid = 1'b1;
      bus.timeData  = v;
      step();
      bus.timeValid = 1'b0;
   endtask

   task automatic sendF(input logic [7:0] v, input logic last);
      bus.freqValid = 1'b1;
      bus.freqData  = v;
      bus.freqLast  = last;
      step();
      bus.freqValid = 1'b0;
      bus.freqLast  = 1'b0;
   endtask

   task automatic pulseSync();
      bus.frameSync = 1'b1;
      step();
      bus.frameSync = 1'b0;
   endtask

   task automatic test_reset();
      bus.frameSync = 1'b0; bus.holdDisplay = 1'b0; bus.trigLevel = 8'd100;
      bus.timeValid = 1'b0; bus.timeData = 8'd0;
      bus.freqValid = 1'b0; bus.freqData = 8'd0; bus.freqLast = 1'b0;
      rst = 1'b1;
      idle(3);
      nCmp++;
      if ({bus.enaTime, bus.weaTime, bus.addraTime, bus.dinaTime} !== 20'd0) begin
         nBad++; $display("FAIL reset_time_port: got %h want 0", {bus.enaTime, bus.weaTime, bus.addraTime, bus.dinaTime});
      end
      nCmp++;
      if ({bus.enaFreq, bus.weaFreq, bus.addraFreq, bus.dinaFreq} !== 20'd0) begin
         nBad++; $display("FAIL reset_freq_port: got %h want 0", {bus.enaFreq, bus.weaFreq, bus.addraFreq, bus.dinaFreq});
      end
      nCmp++;
      if (bus.captureDone !== 1'b0 || bus.timeState !== 2'd0) begin
         nBad++; $display("FAIL reset_state: got done=%b state=%0d want 0/0", bus.captureDone, bus.timeState);
      end
      rst = 1'b0;
      idle(2);
   endtask

   task automatic test_ramp_capture();
      int s0, c0, n, errs;
      pulseSync();
      nCmp++;
      if (bus.timeState !== 2'd1) begin
         nBad++; $display("FAIL ramp_arm: got state %0d want 1", bus.timeState);
      end
      s0 = tN; c0 = cdN;
      for (int k = 0; k < 760; k++) sendT(8'(k));
      idle(3);
      n = tN - s0;
      nCmp++;
      if (n !== 640) begin
         nBad++; $display("FAIL ramp_count: got %0d writes want 640", n);
      end
      nCmp++;
      if (tAddr[s0] !== 10'd0 || tData[s0] !== 8'd100) begin
         nBad++; $display("FAIL ramp_first: got addr %0d data %0d want 0/100", tAddr[s0], tData[s0]);
      end
      errs = 0;
      for (int i = 0; i < 640; i++) begin
         if (tAddr[s0+i] !== 10'(i) || tData[s0+i] !== 8'((100 + i) % 256)) errs++;
      end
      nCmp++;
      if (errs !== 0) begin
         nBad++; $display("FAIL ramp_sequence: got %0d bad writes want 0", errs);
      end
      nCmp++;
      if (cdN - c0 !== 1 || bus.timeState !== 2'd3) begin
         nBad++; $display("FAIL ramp_done: got %0d pulses state %0d want 1/3", cdN - c0, bus.timeState);
      end
   endtask

   task automatic test_hold_in_done();
      int s0;
      bus.holdDisplay = 1'b1;
      pulseSync();
      s0 = tN;
      sendT(8'd0); sendT(8'd200);
      idle(3);
      nCmp++;
      if (bus.timeState !== 2'd3 || tN - s0 !== 0) begin
         nBad++; $display("FAIL done_hold: got state %0d writes %0d want 3/0", bus.timeState, tN - s0);
      end
      bus.holdDisplay = 1'b0;
      pulseSync();
      nCmp++;
      if (bus.timeState !== 2'd1) begin
         nBad++; $display("FAIL done_rearm: got state %0d want 1", bus.timeState);
      end
   endtask

   task automatic test_abort();
      int s0, c0;
      s0 = tN; c0 = cdN;
      for (int k = 0; k < 400; k++) sendT(8'(k));
      bus.holdDisplay = 1'b1;
      for (int k = 400; k < 420; k++) sendT(8'(k));
      idle(3);
      nCmp++;
      if (tN - s0 !== 300) begin
         nBad++; $display("FAIL abort_count: got %0d writes want 300", tN - s0);
      end
      nCmp++;
      if (tAddr[tN-1] !== 10'd299 || tData[tN-1] !== 8'd143) begin
         nBad++; $display("FAIL abort_last: got addr %0d data %0d want 299/143", tAddr[tN-1], tData[tN-1]);
      end
      nCmp++;
      if (cdN - c0 !== 0 || bus.timeState !== 2'd3) begin
         nBad++; $display("FAIL abort_state: got %0d pulses state %0d want 0/3", cdN - c0, bus.timeState);
      end
      bus.holdDisplay = 1'b0;
      idle(1);
   endtask

   task automatic test_freq();
      int s0, errs;
      s0 = fN;
      for (int k = 0; k < 600; k++) sendF(8'(k), (k == 599));
      idle(3);
      nCmp++;
      if (fN - s0 !== 512) begin
         nBad++; $display("FAIL freq_sat_count: got %0d writes want 512", fN - s0);
      end
      errs = 0;
      for (int i = 0; i < 512; i++) begin
         if (fAddr[s0+i] !== 10'(i) || fData[s0+i] !== 8'(i)) errs++;
      end
      nCmp++;
      if (errs !== 0) begin
         nBad++; $display("FAIL freq_sat_seq: got %0d bad writes want 0", errs);
      end
      s0 = fN;
      for (int k = 0; k < 5; k++) sendF(8'(8'hA0 + k), (k == 4));
      idle(3);
      nCmp++;
      if (fN - s0 !== 5 || fAddr[s0] !== 10'd0 || fData[s0] !== 8'hA0 || fAddr[s0+4] !== 10'd4) begin
         nBad++; $display("FAIL freq_realign: got n=%0d first %0d/%h last %0d want 5 0/a0 4",
                          fN - s0, fAddr[s0], fData[s0], fAddr[s0+4]);
      end
      s0 = fN;
      bus.holdDisplay = 1'b1;
      sendF(8'h11, 1'b0);
      bus.holdDisplay = 1'b0;
      for (int k = 1; k < 10; k++) sendF(8'(k), (k == 9));
      idle(3);
      nCmp++;
      if (fN - s0 !== 0) begin
         nBad++; $display("FAIL freq_hold: got %0d writes want 0", fN - s0);
      end
      s0 = fN;
      for (int k = 0; k < 3; k++) sendF(8'(8'h30 + k), (k == 2));
      idle(3);
      nCmp++;
      if (fN - s0 !== 3 || fAddr[s0] !== 10'd0 || fData[s0] !== 8'h30) begin
         nBad++; $display("FAIL freq_after_hold: got n=%0d first %0d/%h want 3 0/30", fN - s0, fAddr[s0], fData[s0]);
      end
   endtask

   task automatic test_auto_timeout();
      int s0;
      pulseSync();
      s0 = tN;
      repeat (4095) sendT(8'd50);
      idle(2);
      nCmp++;
      if (tN - s0 !== 0) begin
         nBad++; $display("FAIL timeout_early: got %0d writes want 0", tN - s0);
      end
      sendT(8'd50);
      idle(2);
`ifdef AUTO_TRIG_EN
      nCmp++;
      if (tN - s0 !== 1 || tAddr[s0] !== 10'd0 || tData[s0] !== 8'd50 || bus.timeState !== 2'd2) begin
         nBad++; $display("FAIL timeout_fire: got n=%0d addr %0d data %0d state %0d want 1 0/50 2",
                          tN - s0, tAddr[s0], tData[s0], bus.timeState);
      end
`else
      nCmp++;
      if (tN - s0 !== 0 || bus.timeState !== 2'd1) begin
         nBad++; $display("FAIL no_timeout: got n=%0d state %0d want 0/1", tN - s0, bus.timeState);
      end
`endif
      repeat (5904) sendT(8'd50);
      idle(3);
`ifdef AUTO_TRIG_EN
      nCmp++;
      if (tN - s0 !== 640 || bus.timeState !== 2'd3) begin
         nBad++; $display("FAIL timeout_capture: got n=%0d state %0d want 640/3", tN - s0, bus.timeState);
      end
`else
      nCmp++;
      if (tN - s0 !== 0 || bus.timeState !== 2'd1) begin
         nBad++; $display("FAIL no_timeout_10000: got n=%0d state %0d want 0/1", tN - s0, bus.timeState);
      end
`endif
   endtask

   task automatic test_reset_mid_capture();
      int s0;
      pulseSync();
      nCmp++;
      if (bus.timeState !== 2'd1) begin
         nBad++; $display("FAIL mid_arm: got state %0d want 1", bus.timeState);
      end
      sendT(8'd50);
      for (int k = 0; k < 10; k++) sendT(8'(150 + k));
      nCmp++;
      if (bus.enaTime !== 1'b1 || bus.addraTime !== 10'd9 || bus.timeState !== 2'd2) begin
         nBad++; $display("FAIL mid_capture: got ena %b addr %0d state %0d want 1 9 2",
                          bus.enaTime, bus.addraTime, bus.timeState);
      end
      #1 rst = 1'b1;
      #1;
      nCmp++;
      if ({bus.enaTime, bus.weaTime, bus.addraTime, bus.dinaTime, bus.captureDone, bus.timeState} !== 23'd0) begin
         nBad++; $display("FAIL mid_reset: got ena %b addr %0d data %0d state %0d want all 0",
                          bus.enaTime, bus.addraTime, bus.dinaTime, bus.timeState);
      end
      idle(2);
      rst = 1'b0;
      idle(2);
      pulseSync();
      s0 = tN;
      sendT(8'd50);
      sendT(8'd150);
      idle(3);
      nCmp++;
      if (tN - s0 !== 1 || tAddr[s0] !== 10'd0 || tData[s0] !== 8'd150) begin
         nBad++; $display("FAIL restart: got n=%0d addr %0d data %0d want 1 0/150", tN - s0, tAddr[s0], tData[s0]);
      end
   endtask

   initial begin
      test_reset();
      test_ramp_capture();
      test_hold_in_done();
      test_abort();
      test_freq();
      test_auto_timeout();
      test_reset_mid_capture();
      nCmp++;
      if (weBad !== 0) begin
         nBad++; $display("FAIL ena_eq_we: got %0d cycles with ena!=we want 0", weBad);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end
endmodule
